// File: rtl/i2c_wr_master.sv
// i2c_wr_master: write-only I2C master that sends one 3-byte frame per request.
// A frame is START, 3 x (8 data bits + ACK), then STOP. Each bit slot is four
// quarters of DIV clk cycles. SCL is low in q0/q1 and high in q2/q3. SDA
// changes at q0 entry.
//
// Parameters:
//   DIV      clk cycles per SCL quarter-period (2..1023)
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    one-cycle request, accepted only in IDLE (and not on the done cycle)
//   data     frame: [23:16] address+R/W, [15:8] byte 1, [7:0] byte 2, MSB first
//   busy     high from the cycle after an accepted start until done
//   done     one-cycle pulse at frame end
//   ack_err  sticky NACK flag for the current frame
//   i2c_sclk SCL, push-pull, idle high
//   sda      open-drain SDA control (1 = release, 0 = drive low)
//   sda_in   sampled SDA bus level
//
// Build option:
//   I2C_NACK_ABORT_EN  when defined, a NACK ends the data phase after that ACK
//                      slot and the frame goes straight to STOP.
module i2c_wr_master #(
  parameter int unsigned DIV = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        i2c_sclk,
  output logic        sda,
  input  logic        sda_in
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BITS  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [9:0] CNT_LAST = 10'(DIV - 1);

  logic [1:0]  state,    state_n;
  logic [9:0]  qcnt,     qcnt_n;
  logic [1:0]  quarter,  quarter_n;
  logic [3:0]  bit_pos,  bit_pos_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [23:0] shreg,    shreg_n;
  logic        ack_n;
  logic        done_n;
  logic        sclk_n;
  logic        sda_n;
  logic        tick;
  logic        slot_end;
  logic        abort_now;

  assign tick     = (qcnt == CNT_LAST);
  assign slot_end = tick && (quarter == 2'd3);

`ifdef I2C_NACK_ABORT_EN
  // ack_err is cleared on start and sampled in q2, so at the end of an ACK
  // slot it is only set if this frame has just seen its first NACK.
  assign abort_now = ack_err;
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    qcnt_n     = qcnt;
    quarter_n  = quarter;
    bit_pos_n  = bit_pos;
    byte_idx_n = byte_idx;
    shreg_n    = shreg;
    ack_n      = ack_err;
    done_n     = 1'b0;

    if (state != S_IDLE) begin
      if (tick) begin
        qcnt_n    = '0;
        quarter_n = quarter + 2'd1;
      end else begin
        qcnt_n = qcnt + 10'd1;
      end
    end

    case (state)
      S_IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start && !done) begin
          state_n    = S_START;
          qcnt_n     = '0;
          quarter_n  = '0;
          bit_pos_n  = '0;
          byte_idx_n = '0;
          shreg_n    = data;
          ack_n      = 1'b0;
        end
      end
      S_START: begin
        if (slot_end) state_n = S_BITS;
      end
      S_BITS: begin
        if (bit_pos == 4'd8 && quarter == 2'd2 && tick && sda_in) ack_n = 1'b1;
        if (slot_end) begin
          if (bit_pos == 4'd8) begin
            if (byte_idx == 2'd2 || abort_now) begin
              state_n = S_STOP;
            end else begin
              byte_idx_n = byte_idx + 2'd1;
              bit_pos_n  = '0;
            end
          end else begin
            bit_pos_n = bit_pos + 4'd1;
            shreg_n   = {shreg[22:0], 1'b0};
          end
        end
      end
      default: begin
        if (slot_end) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  // Bus levels are decoded from the next-state values and registered, so
  // SCL/SDA come straight from flops and line up with the slot boundaries.
  always_comb begin
    sclk_n = 1'b1;
    sda_n  = 1'b1;
    case (state_n)
      S_START: begin
        sclk_n = (quarter_n != 2'd3);
        sda_n  = (quarter_n < 2'd2);
      end
      S_BITS: begin
        sclk_n = quarter_n[1];
        sda_n  = (bit_pos_n == 4'd8) ? 1'b1 : shreg_n[23];
      end
      S_STOP: begin
        sclk_n = (quarter_n != 2'd0);
        sda_n  = quarter_n[1];
      end
      default: begin
        sclk_n = 1'b1;
        sda_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      quarter  <= '0;
      bit_pos  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      ack_err  <= 1'b0;
      done     <= 1'b0;
      i2c_sclk <= 1'b1;
      sda      <= 1'b1;
    end else begin
      state    <= state_n;
      qcnt     <= qcnt_n;
      quarter  <= quarter_n;
      bit_pos  <= bit_pos_n;
      byte_idx <= byte_idx_n;
      shreg    <= shreg_n;
      ack_err  <= ack_n;
      done     <= done_n;
      i2c_sclk <= sclk_n;
      sda      <= sda_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_wr_master.sv
// Self-checking bench for i2c_wr_master: randomized frames with a behavioural
// slave and protocol monitor; expectations derived from frame-level rules.
module tb_i2c_wr_master;

  localparam int unsigned DIV = 2;
`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] data;
  logic        busy, done, ack_err, i2c_sclk, sda, sda_in;
  logic        slave_low = 1'b0;
  logic [2:0]  nack_mask = 3'b000;

  // Open-drain bus: either side may pull low.
  assign sda_in = sda & ~slave_low;

  always #5 clk = ~clk;

  i2c_wr_master #(.DIV(DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .i2c_sclk (i2c_sclk),
    .sda      (sda),
    .sda_in   (sda_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor and slave model, all sampled on the falling clk edge.
  int cyc = 0;
  int fall_cnt = 0;
  int busy_cyc = 0;
  int start_edges = 0;
  int stop_edges = 0;
  int done_cnt = 0;
  bit rise_sda[$];
  int rise_t[$];

  initial begin
    logic prev_sclk, prev_sda, prev_busy;
    prev_sclk = 1'b1;
    prev_sda  = 1'b1;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !prev_busy) begin
        rise_sda.delete();
        rise_t.delete();
        fall_cnt    = 0;
        busy_cyc    = 0;
        start_edges = 0;
        stop_edges  = 0;
        done_cnt    = 0;
      end
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (prev_sclk && !i2c_sclk) fall_cnt++;
      if (!prev_sclk && i2c_sclk) begin
        rise_sda.push_back(sda);
        rise_t.push_back(cyc);
      end
      if (prev_sclk && i2c_sclk && (sda != prev_sda)) begin
        if (sda) stop_edges++;
        else     start_edges++;
      end
      // Slot n (0-based) follows the (n+1)th SCL fall; every 9th slot is ACK.
      slave_low = busy && fall_cnt > 0 && fall_cnt <= 27 && (fall_cnt % 9 == 0)
                  && !nack_mask[(fall_cnt - 1) / 9];
      prev_sclk = i2c_sclk;
      prev_sda  = sda;
      prev_busy = busy;
    end
  end

  task automatic run_frame(input logic [23:0] d, input logic [2:0] nm, input int inj_at,
                           input int hold, input bit b2b);
    int k, nb, exp_cyc, bad;
    logic [7:0] got_byte;
    nack_mask = nm;
    @(negedge clk);
    start = 1'b1;
    data  = d;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    data  = 24'($urandom);
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
      if (k == inj_at) begin
        start = 1'b1;
        data  = ~d;
      end else begin
        start = 1'b0;
      end
    end
    check_eq("done_seen", 32'(k < 2000), 32'd1);
    check_eq("busy_at_done", busy, 1'b0);
    if (b2b) begin
      start = 1'b1;
      data  = ~d;
      @(negedge clk);
      start = 1'b0;
      check_eq("start_on_done_ignored", busy, 1'b0);
    end
    repeat (3) @(negedge clk);
    check_eq("idle_after_frame", busy, 1'b0);
    check_eq("done_pulses", done_cnt, 1);

    nb = 3;
    for (int b = 0; b < 3; b++)
      if (ABORT && nm[b] && nb == 3) nb = b + 1;
    exp_cyc = (2 + 9 * nb) * 4 * int'(DIV);
    check_eq("frame_len", busy_cyc, exp_cyc);
    check_eq("ack_err", ack_err, |nm);
    check_eq("scl_rises", rise_sda.size(), 9 * nb + 1);
    if (rise_sda.size() == 9 * nb + 1) begin
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 8; i++) got_byte[7 - i] = rise_sda[9 * b + i];
        check_eq("byte", got_byte, d[23 - 8 * b -: 8]);
        check_eq("ack_released", rise_sda[9 * b + 8], 1'b1);
      end
      check_eq("stop_sda_low_at_scl_rise", rise_sda[9 * nb], 1'b0);
      bad = 0;
      for (int i = 1; i < 9 * nb; i++)
        if (rise_t[i] - rise_t[i - 1] != 4 * int'(DIV)) bad++;
      check_eq("scl_period", bad, 0);
    end
    check_eq("start_edges", start_edges, 1);
    check_eq("stop_edges", stop_edges, 1);
  endtask

  task automatic reset_mid_frame(input logic [23:0] d);
    int k;
    nack_mask = 3'b000;
    @(negedge clk);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (busy_cyc < 100 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_eq("reached_clk100", 32'(busy_cyc >= 100), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rst_sclk", i2c_sclk, 1'b1);
    check_eq("rst_sda", sda, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ack_err", ack_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    data    = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_sclk", i2c_sclk, 1'b1);
    check_eq("reset_sda", sda, 1'b1);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_ack_err", ack_err, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(24'h341E00, 3'b000, 0, 1, 1'b0);
    run_frame(24'h341E00, 3'b001, 0, 1, 1'b0);
    run_frame(24'($urandom), 3'b000, 50, 1, 1'b0);
    run_frame(24'($urandom), 3'b010, 0, 3, 1'b1);
    run_frame(24'($urandom), 3'b000, 0, 1, 1'b0);
    reset_mid_frame(24'($urandom));
    run_frame(24'($urandom), 3'b000, 0, 1, 1'b0);
    for (int n = 0; n < 8; n++)
      run_frame(24'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 80)),
                int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_wr_master.md
I2C_WR_MASTER -- requirements
Module: i2c_wr_master

Interface
REQ-001 SHALL have parameter DIV, default 125, meaning clk cycles per SCL quarter-period (50 MHz clk gives 100 kHz SCL); legal range 2..1023.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to send one 3-byte write frame.
REQ-005 SHALL have port data  input  24  frame to send: [23:16] device address+R/W, [15:8] byte 1, [7:0] byte 2; MSB first.
REQ-006 SHALL have port busy  output  1  high from accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-008 SHALL have port ack_err  output  1  sticky NACK flag for the current frame.
REQ-009 SHALL have port i2c_sclk  output  1  I2C clock, push-pull, idle high.
REQ-010 SHALL have port sda  output  1  open-drain SDA control: 1 releases the bus, 0 drives low.
REQ-011 SHALL have port sda_in  input  1  sampled SDA bus level.

Function
REQ-012 SHALL use a quarter counter (0..DIV-1) and a quarter index q0..q3; each slot is 4 quarters = 4*DIV clk.
REQ-013 SHALL implement FSM IDLE -> START -> BITS -> STOP -> IDLE.
REQ-014 SHALL accept start only in IDLE: latch data, clear ack_err, set busy the next cycle; start while busy is ignored.
REQ-015 START slot: q0,q1 sda=1 sclk=1; q2 sda=0 sclk=1; q3 sda=0 sclk=0.
REQ-016 BITS: 27 slots (per byte: 8 data, then 1 ACK); sda updates at q0 entry; sclk low in q0,q1 and high in q2,q3.
REQ-017 In data slots, sda SHALL equal the current latched bit; in ACK slots, sda=1 (released).
REQ-018 At the last clk of q2 in each ACK slot, SHALL sample sda_in; 1 = NACK and sets ack_err.
REQ-019 STOP slot: q0 sda=0 sclk=0; q1 sda=0 sclk=1; q2,q3 sda=1 sclk=1.
REQ-020 Frame length SHALL be 29 slots = 116*DIV clk from the first cycle busy is high; done pulses on the cycle after the STOP q3 ends, and busy falls on that same cycle.
REQ-021 Back-to-back operation: start asserted on the done cycle SHALL be ignored; a new start is accepted from the next cycle on.
REQ-022 SDA SHALL never change while sclk=1, except for START/STOP edges.
REQ-023 ack_err SHALL hold its value after done until the next accepted start.

Reset
REQ-024 On reset_n=0, SHALL immediately force IDLE: i2c_sclk=1, sda=1, busy=0, done=0, ack_err=0, counters=0, data register=0.
REQ-025 Reset mid-frame SHALL abort without issuing STOP; the bus is released on the reset edge.

Configuration
REQ-026 Macro I2C_NACK_ABORT_EN: when defined, a NACK SHALL end BITS after that ACK slot and go straight to the STOP slot (frame = (2+9k)*4*DIV clk for NACK in byte k); when undefined, all 27 BITS slots SHALL be sent regardless of NACK, with only ack_err recording it.

Verification
REQ-027 DIV=2, data=24'h34_1E_00, slave ACKs all: bytes 34,1E,00 are seen on SCL rising edges; ack_err=0; done exactly 232 clk after busy rises.
REQ-028 DIV=2, slave NACKs the address byte: ack_err=1; with I2C_NACK_ABORT_EN, done at 88 clk (frame = 11 slots); without it, done at 232 clk.
REQ-029 start pulsed 50 clk into a frame with a different data value: ignored; the original frame completes unchanged.
REQ-030 reset_n low at clk 100 of a frame: sclk=1, sda=1, busy=0 in the same cycle; the next start produces a complete correct frame.
REQ-031 Protocol checker: every SDA transition with sclk=1 is exactly one START (falling) and one STOP (rising) per frame; SCL period = 4*DIV clk, constant.
REQ-032 start held high for 3 cycles in IDLE: exactly one frame is sent.
